// File: rtl/ps2_scan_decoder.sv
// PS/2 Set-2 scan-code decoder: folds E0/F0 prefixes into key events,
// tracks the held key and shift state, translates to ASCII, counts presses.
module ps2_scan_decoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             key_valid,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic             key_release,
  output logic             key_repeat,
  output logic [7:0]       key_ascii,
  output logic             key_down,
  output logic [7:0]       held_code,
  output logic             shift_down,
  output logic [CNT_W-1:0] press_cnt,
  output logic             proto_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXTBRK
  } state_t;

  state_t state;
  state_t state_nx;

  logic ev_fire;
  logic ev_ext;
  logic ev_rel;
  logic err_hit;
  logic is_e0;
  logic is_f0;
  logic is_drop;
  logic held_ext;
  logic lsh;
  logic rsh;
  logic is_match;
  logic is_rep;

  function automatic logic [7:0] to_ascii(
    input logic [7:0] c,
    input logic       up
  );
    logic [7:0] a;
    a = 8'h00;
    case (c)
      8'h1C: a = 8'h61;
      8'h32: a = 8'h62;
      8'h21: a = 8'h63;
      8'h23: a = 8'h64;
      8'h24: a = 8'h65;
      8'h2B: a = 8'h66;
      8'h34: a = 8'h67;
      8'h33: a = 8'h68;
      8'h43: a = 8'h69;
      8'h3B: a = 8'h6A;
      8'h42: a = 8'h6B;
      8'h4B: a = 8'h6C;
      8'h3A: a = 8'h6D;
      8'h31: a = 8'h6E;
      8'h44: a = 8'h6F;
      8'h4D: a = 8'h70;
      8'h15: a = 8'h71;
      8'h2D: a = 8'h72;
      8'h1B: a = 8'h73;
      8'h2C: a = 8'h74;
      8'h3C: a = 8'h75;
      8'h2A: a = 8'h76;
      8'h1D: a = 8'h77;
      8'h22: a = 8'h78;
      8'h35: a = 8'h79;
      8'h1A: a = 8'h7A;
      8'h45: a = 8'h30;
      8'h16: a = 8'h31;
      8'h1E: a = 8'h32;
      8'h26: a = 8'h33;
      8'h25: a = 8'h34;
      8'h2E: a = 8'h35;
      8'h36: a = 8'h36;
      8'h3D: a = 8'h37;
      8'h3E: a = 8'h38;
      8'h46: a = 8'h39;
      8'h29: a = 8'h20;
      8'h5A: a = 8'h0D;
      8'h66: a = 8'h08;
      default: a = 8'h00;
    endcase
    // letters occupy 61..7A; shift folds them to upper case
    if (up && a >= 8'h61 && a <= 8'h7A)
      a = a - 8'h20;
    return a;
  endfunction

  assign is_e0    = (byte_data == 8'hE0);
  assign is_f0    = (byte_data == 8'hF0);
  assign is_drop  = byte_data inside {8'hE1, 8'hFA, 8'hAA,
                                      8'hEE, 8'hFE, 8'h00, 8'hFF};
  assign is_match = (byte_data == held_code) && (ev_ext == held_ext);
  assign is_rep   = key_down && is_match;
  assign shift_down = lsh | rsh;

  always_comb begin
    state_nx = state;
    ev_fire  = 1'b0;
    ev_ext   = 1'b0;
    ev_rel   = 1'b0;
    err_hit  = 1'b0;
    if (byte_valid) begin
      unique case (state)
        S_IDLE: begin
          if (is_e0)
            state_nx = S_EXT;
          else if (is_f0)
            state_nx = S_BRK;
          else if (!is_drop)
            ev_fire = 1'b1;
        end
        S_EXT: begin
          if (is_f0)
            state_nx = S_EXTBRK;
          else if (!is_e0) begin
            ev_fire  = 1'b1;
            ev_ext   = 1'b1;
            state_nx = S_IDLE;
          end
        end
        S_BRK: begin
          state_nx = S_IDLE;
          if (is_e0 || is_f0)
            err_hit = 1'b1;
          else begin
            ev_fire = 1'b1;
            ev_rel  = 1'b1;
          end
        end
        S_EXTBRK: begin
          state_nx = S_IDLE;
          if (is_e0 || is_f0)
            err_hit = 1'b1;
          else begin
            ev_fire = 1'b1;
            ev_ext  = 1'b1;
            ev_rel  = 1'b1;
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state       <= S_IDLE;
      key_valid   <= 1'b0;
      key_code    <= 8'h00;
      key_ext     <= 1'b0;
      key_release <= 1'b0;
      key_repeat  <= 1'b0;
      key_ascii   <= 8'h00;
      key_down    <= 1'b0;
      held_code   <= 8'h00;
      held_ext    <= 1'b0;
      lsh         <= 1'b0;
      rsh         <= 1'b0;
      press_cnt   <= '0;
      proto_err   <= 1'b0;
    end else begin
      state     <= state_nx;
      key_valid <= 1'b0;
      if (err_hit)
        proto_err <= 1'b1;
      if (ev_fire) begin
        key_valid   <= 1'b1;
        key_code    <= byte_data;
        key_ext     <= ev_ext;
        key_release <= ev_rel;
        key_ascii   <= ev_ext ? 8'h00 : to_ascii(byte_data, shift_down);
        if (!ev_rel) begin
          key_repeat <= is_rep;
          if (!is_rep) begin
            press_cnt <= press_cnt + CNT_W'(1);
            held_code <= byte_data;
            held_ext  <= ev_ext;
            key_down  <= 1'b1;
          end
          if (!ev_ext && byte_data == 8'h12)
            lsh <= 1'b1;
          if (!ev_ext && byte_data == 8'h59)
            rsh <= 1'b1;
        end else begin
          key_repeat <= 1'b0;
          if (is_match)
            key_down <= 1'b0;
          if (!ev_ext && byte_data == 8'h12)
            lsh <= 1'b0;
          if (!ev_ext && byte_data == 8'h59)
            rsh <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Scoreboard bench for ps2_scan_decoder: directed Set-2 sequences plus
// random key actions against a sequence-level reference model.
module tb_ps2_scan_decoder;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_release;
  logic       key_repeat;
  logic [7:0] key_ascii;
  logic       key_down;
  logic [7:0] held_code;
  logic       shift_down;
  logic [7:0] press_cnt;
  logic       proto_err;

  ps2_scan_decoder #(.CNT_W(8)) dut (
    .clk(clk),
    .clrn(clrn),
    .byte_valid(byte_valid),
    .byte_data(byte_data),
    .key_valid(key_valid),
    .key_code(key_code),
    .key_ext(key_ext),
    .key_release(key_release),
    .key_repeat(key_repeat),
    .key_ascii(key_ascii),
    .key_down(key_down),
    .held_code(held_code),
    .shift_down(shift_down),
    .press_cnt(press_cnt),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] code;
    logic       ext;
    logic       rel;
    logic       rep;
    logic [7:0] ascii;
  } ev_t;

  ev_t sbq[$];
  logic [7:0] seq[$];
  int tests = 0;
  int fails = 0;

  logic       m_down;
  logic       m_hext;
  logic [7:0] m_hcode;
  logic       m_lsh;
  logic       m_rsh;
  logic       m_err;
  int         m_cnt;

  logic [7:0] letters[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B,
    8'h34, 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
    8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digits[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
    8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  logic [7:0] pool[14] = '{8'h1C, 8'h32, 8'h1A, 8'h4D, 8'h12, 8'h59,
    8'h16, 8'h45, 8'h29, 8'h5A, 8'h66, 8'h75, 8'h6B, 8'h0D};

  function automatic logic [7:0] ascii_of(input logic [7:0] c,
                                          input logic ext, input logic up);
    if (ext) return 8'h00;
    for (int i = 0; i < 26; i++)
      if (letters[i] == c) return (up ? 8'h41 : 8'h61) + 8'(i);
    for (int i = 0; i < 10; i++)
      if (digits[i] == c) return 8'h30 + 8'(i);
    if (c == 8'h29) return 8'h20;
    if (c == 8'h5A) return 8'h0D;
    if (c == 8'h66) return 8'h08;
    return 8'h00;
  endfunction

  task automatic model_reset();
    seq.delete();
    m_down = 0; m_hext = 0; m_hcode = 0;
    m_lsh = 0; m_rsh = 0; m_err = 0; m_cnt = 0;
  endtask

  task automatic model_event(input logic [7:0] b, input logic ext,
                             input logic rel);
    ev_t e;
    e.code  = b;
    e.ext   = ext;
    e.rel   = rel;
    e.ascii = ascii_of(b, ext, m_lsh | m_rsh);
    e.rep   = 0;
    if (!rel) begin
      e.rep = m_down && b == m_hcode && ext == m_hext;
      if (!e.rep) begin
        m_cnt = (m_cnt + 1) % 256;
        m_hcode = b; m_hext = ext; m_down = 1;
      end
      if (!ext && b == 8'h12) m_lsh = 1;
      if (!ext && b == 8'h59) m_rsh = 1;
    end else begin
      if (b == m_hcode && ext == m_hext) m_down = 0;
      if (!ext && b == 8'h12) m_lsh = 0;
      if (!ext && b == 8'h59) m_rsh = 0;
    end
    sbq.push_back(e);
  endtask

  // The model keeps the pending prefix bytes and interprets the sequence
  // once a non-prefix byte closes it.
  task automatic model_byte(input logic [7:0] b);
    logic has_e0, has_f0;
    has_e0 = 0; has_f0 = 0;
    if (seq.size() == 0 && b inside {8'hE1, 8'hFA, 8'hAA, 8'hEE,
                                     8'hFE, 8'h00, 8'hFF})
      return;
    foreach (seq[i]) begin
      if (seq[i] == 8'hE0) has_e0 = 1;
      if (seq[i] == 8'hF0) has_f0 = 1;
    end
    if (b == 8'hE0) begin
      if (has_f0) m_err = 1;
      seq.delete();
      if (!has_f0) seq.push_back(8'hE0);
    end else if (b == 8'hF0) begin
      if (has_f0) begin
        m_err = 1;
        seq.delete();
      end else seq.push_back(8'hF0);
    end else begin
      model_event(b, has_e0, has_f0);
      seq.delete();
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_levels();
    check("pending_events", sbq.size(), 0);
    check("key_down", key_down, m_down);
    check("held_code", held_code, m_hcode);
    check("shift_down", shift_down, m_lsh | m_rsh);
    check("press_cnt", press_cnt, m_cnt);
    check("proto_err", proto_err, m_err);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    byte_valid = 1;
    byte_data  = b;
    model_byte(b);
    @(negedge clk);
    byte_valid = 0;
    #1 check_levels();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    clrn = 0;
    byte_valid = 0;
    model_reset();
    sbq.delete();
    @(negedge clk);
    check("rst_outputs", {key_valid, key_code, key_ext, key_release,
          key_repeat, key_ascii, key_down, held_code, shift_down,
          press_cnt, proto_err}, 0);
    @(negedge clk);
    clrn = 1;
  endtask

  always @(negedge clk) begin
    if (clrn && key_valid) begin
      tests++;
      if (sbq.size() == 0) begin
        fails++;
        $display("FAIL unexpected_event: got code=%h ext=%b rel=%b, expected none",
                 key_code, key_ext, key_release);
      end else begin
        ev_t e;
        e = sbq.pop_front();
        if ({key_code, key_ext, key_release, key_repeat, key_ascii} !==
            {e.code, e.ext, e.rel, e.rep, e.ascii}) begin
          fails++;
          $display("FAIL event: got code=%h ext=%b rel=%b rep=%b ascii=%h, expected code=%h ext=%b rel=%b rep=%b ascii=%h",
                   key_code, key_ext, key_release, key_repeat, key_ascii,
                   e.code, e.ext, e.rel, e.rep, e.ascii);
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] t1[3]  = '{8'h1C, 8'hF0, 8'h1C};
    logic [7:0] t2[5]  = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C};
    logic [7:0] t3[6]  = '{8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12};
    logic [7:0] t4[5]  = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75};
    logic [7:0] t5[3]  = '{8'hF0, 8'hF0, 8'h1C};
    logic [7:0] t7[10] = '{8'hFA, 8'hAA, 8'h59, 8'h2C, 8'hE0, 8'hE0,
                           8'h4D, 8'hF0, 8'hE0, 8'h59};
    model_reset();
    apply_reset();
    foreach (t1[i]) send_byte(t1[i]);
    apply_reset();
    foreach (t2[i]) send_byte(t2[i]);
    apply_reset();
    foreach (t3[i]) send_byte(t3[i]);
    apply_reset();
    foreach (t4[i]) send_byte(t4[i]);
    apply_reset();
    foreach (t5[i]) send_byte(t5[i]);
    apply_reset();
    foreach (t7[i]) send_byte(t7[i]);
    apply_reset();
    for (int i = 0; i < 256; i++) begin
      send_byte(8'h16);
      send_byte(8'hF0);
      send_byte(8'h16);
    end
    check("press_wrap", press_cnt, 0);
    send_byte(8'hE0);
    apply_reset();
    send_byte(8'h75);
    check("post_reset_ext", key_ext, 0);
    apply_reset();
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 9) == 0)
        send_byte(8'($urandom_range(0, 255)));
      else begin
        if ($urandom_range(0, 2) == 0) send_byte(8'hE0);
        if ($urandom_range(0, 1) == 0) send_byte(8'hF0);
        send_byte(pool[$urandom_range(0, 13)]);
      end
    end
    repeat (3) @(negedge clk);
    check("final_queue", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
